// File: rtl/codec_i2s_intf_pkg.sv
// Shared constants and types for the equalizer-to-I2S-codec bridge.
// One frame is 2**CNT_W clk cycles holding one left and one right DATA_W word.
package codec_pkg;

  localparam int CNT_W    = 10;
  localparam int SCLK_BIT = 4;
  localparam int MCLK_BIT = 1;
  localparam int DATA_W   = 2 ** (CNT_W - SCLK_BIT - 2);
  localparam int FRAME_W  = 2 * DATA_W;
  localparam int PHASE_W  = SCLK_BIT + 1;

  localparam logic [PHASE_W-1:0] RISE_PHASE    = 5'h0F;
  localparam logic [PHASE_W-1:0] FALL_PHASE    = 5'h1F;
  localparam logic [CNT_W-1:0]   WORD_UPD_CNT  = 10'h010;
  localparam logic [CNT_W-1:0]   TX_LOAD_CNT   = 10'h01F;
  localparam logic [CNT_W-1:0]   FRAME_END_CNT = 10'h3FF;

  // Codec link bring-up: held in reset, one untrusted frame, then running.
  typedef enum logic [1:0] {
    LINK_RESET   = 2'd0,
    LINK_DISCARD = 2'd1,
    LINK_RUN     = 2'd2
  } link_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] lft;
    logic [DATA_W-1:0] rht;
  } stereo_t;

  // Position of the counter inside the current SCLK period.
  function automatic logic [PHASE_W-1:0] bit_phase(input logic [CNT_W-1:0] cnt);
    return cnt[PHASE_W-1:0];
  endfunction

endpackage

// File: rtl/codec_i2s_intf_if.sv
// Core-side sample bus: DAC words from the equalizer, ADC words plus valid back.
// master = equalizer core, slave = codec bridge.
interface codec_i2s_intf_if;
  import codec_pkg::*;

  logic [DATA_W-1:0] lft_dac;
  logic [DATA_W-1:0] rht_dac;
  logic [DATA_W-1:0] lft_adc;
  logic [DATA_W-1:0] rht_adc;
  logic              valid;

  modport master (
    output lft_dac,
    output rht_dac,
    input  lft_adc,
    input  rht_adc,
    input  valid
  );

  modport slave (
    input  lft_dac,
    input  rht_dac,
    output lft_adc,
    output rht_adc,
    output valid
  );

endinterface

// File: rtl/codec_i2s_intf_clk_gen.sv
// Frame timebase for the codec link: counter, clock taps, bit strobes and the
// codec reset / frame-trust sequencing.
module codec_clk_gen
  import codec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             lrclk,
  output logic             sclk,
  output logic             mclk,
  output logic             rise_evt,
  output logic             fall_evt,
  output logic             rstn,
  output logic             frame_ok
);

  logic [CNT_W-1:0] cnt_r;
  link_state_e      link_state_r;
  logic             rstn_r;
  logic             frame_ok_r;
  logic             frame_end_s;

  // Free-running frame counter; all codec clocks are taps of it
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

  assign frame_end_s = (cnt_r == FRAME_END_CNT);

  // Clock outputs are flop bits directly, so they cannot glitch
  assign cnt      = cnt_r;
  assign lrclk    = cnt_r[CNT_W-1];
  assign sclk     = cnt_r[SCLK_BIT];
  assign mclk     = cnt_r[MCLK_BIT];
  assign rise_evt = (bit_phase(cnt_r) == RISE_PHASE);
  assign fall_evt = (bit_phase(cnt_r) == FALL_PHASE);
  assign rstn     = rstn_r;
  assign frame_ok = frame_ok_r;

  // Release codec after one frame, then drop one more frame before trusting data
  always_ff @(posedge clk) begin
    if (rst) begin
      link_state_r <= LINK_RESET;
      rstn_r       <= 1'b0;
      frame_ok_r   <= 1'b0;
    end else begin
      case (link_state_r)
        LINK_RESET: begin
          if (frame_end_s) begin
            link_state_r <= LINK_DISCARD;
            rstn_r       <= 1'b1;
          end
        end
        LINK_DISCARD: begin
          if (frame_end_s) begin
            link_state_r <= LINK_RUN;
            frame_ok_r   <= 1'b1;
          end
        end
        LINK_RUN: begin
          link_state_r <= LINK_RUN;
          rstn_r       <= 1'b1;
          frame_ok_r   <= 1'b1;
        end
        default: begin
          link_state_r <= LINK_RESET;
          rstn_r       <= 1'b0;
          frame_ok_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/codec_i2s_intf.sv
// I2S bridge between the equalizer core and an external ADC+DAC codec.
// Deserializes SDout into stereo sample words and serializes DAC words onto SDin.
module codec_i2s_intf
  import codec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  codec_i2s_intf_if.slave  core,
  input  logic             SDout,
  output logic             SDin,
  output logic             LRCLK,
  output logic             SCLK,
  output logic             MCLK,
  output logic             RSTn
);

  logic [CNT_W-1:0]  cnt_s;
  logic              rise_evt_s;
  logic              fall_evt_s;
  logic              frame_ok_s;
  stereo_t           rx_shft_r;
  stereo_t           tx_shft_r;
  logic [DATA_W-1:0] lft_adc_r;
  logic [DATA_W-1:0] rht_adc_r;
  logic              valid_r;

  codec_clk_gen u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt_s),
    .lrclk    (LRCLK),
    .sclk     (SCLK),
    .mclk     (MCLK),
    .rise_evt (rise_evt_s),
    .fall_evt (fall_evt_s),
    .rstn     (RSTn),
    .frame_ok (frame_ok_s)
  );

  // ADC capture: one bit per SCLK rise, MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shft_r <= '0;
    end else if (rise_evt_s) begin
      rx_shft_r <= stereo_t'({rx_shft_r[FRAME_W-2:0], SDout});
    end
  end

  // Rise 0 of a frame completes the previous right word (I2S 1-bit delay),
  // so the whole stereo pair is ready one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_adc_r <= '0;
      rht_adc_r <= '0;
      valid_r   <= 1'b0;
    end else if (cnt_s == WORD_UPD_CNT) begin
      lft_adc_r <= rx_shft_r.lft;
      rht_adc_r <= rx_shft_r.rht;
      valid_r   <= frame_ok_s;
    end else begin
      valid_r   <= 1'b0;
    end
  end

  // DAC shifter: load at the first in-frame SCLK fall, shift on every other fall
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shft_r <= '0;
    end else if (fall_evt_s) begin
      if (cnt_s == TX_LOAD_CNT) begin
        tx_shft_r <= stereo_t'({core.lft_dac, core.rht_dac});
      end else begin
        tx_shft_r <= stereo_t'({tx_shft_r[FRAME_W-2:0], 1'b0});
      end
    end
  end

  assign SDin         = tx_shft_r[FRAME_W-1];
  assign core.lft_adc = lft_adc_r;
  assign core.rht_adc = rht_adc_r;
  assign core.valid   = valid_r;

endmodule

// File: tb/tb_codec_i2s_intf.sv
// Self-checking bench for codec_i2s_intf: I2S codec model, SDin decoder,
// directed vector table plus reset, hold-off, loopback and mid-frame reset sequences.
module tb_codec_i2s_intf;
  import codec_pkg::*;

  typedef struct packed {
    logic [15:0] codec_l;
    logic [15:0] codec_r;
    logic [15:0] dac_l;
    logic [15:0] dac_r;
    logic [15:0] exp_adc_l;
    logic [15:0] exp_adc_r;
    logic [15:0] exp_sd_l;
    logic [15:0] exp_sd_r;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sdout, sdin, lrclk, sclk, mclk, rstn;
  logic loopback  = 1'b0;
  logic codec_bit = 1'b0;
  logic [15:0] codec_l = 16'h0000;
  logic [15:0] codec_r = 16'h0000;

  int errors = 0;
  int checks = 0;

  codec_i2s_intf_if core_if();

  codec_i2s_intf dut (
    .clk   (clk),
    .rst   (rst),
    .core  (core_if),
    .SDout (sdout),
    .SDin  (sdin),
    .LRCLK (lrclk),
    .SCLK  (sclk),
    .MCLK  (mclk),
    .RSTn  (rstn)
  );

  always #10 clk = ~clk;

  assign sdout = loopback ? sdin : codec_bit;

  // Reference timebase: clock edges since reset release
  int unsigned c = 0;
  logic [9:0]  bcnt;
  assign bcnt = c[9:0];
  always @(posedge clk) c <= rst ? 0 : c + 1;

  // Clock taps, RSTn and valid placement checked every cycle
  int wave_err = 0;
  int vpos_err = 0;
  int vcount   = 0;
  int unsigned v_c = 0;
  logic [15:0] v_l = 16'h0000;
  logic [15:0] v_r = 16'h0000;
  always @(negedge clk) begin
    if (!rst) begin
      if (lrclk !== bcnt[9] || sclk !== bcnt[4] || mclk !== bcnt[1] ||
          rstn !== (c >= 32'd1024))
        wave_err <= wave_err + 1;
      if (core_if.valid === 1'b1) begin
        vcount <= vcount + 1;
        v_l    <= core_if.lft_adc;
        v_r    <= core_if.rht_adc;
        v_c    <= c;
        if (bcnt != 10'h011 || c < 32'd2065) vpos_err <= vpos_err + 1;
      end else if (core_if.valid !== 1'b0) begin
        vpos_err <= vpos_err + 1;
      end
    end
  end

  // Codec ADC model: new bit after every SCLK fall; fall 0 is the LRCLK fall
  int   fidx = 0;
  logic lr_fall_prev = 1'b0;
  function automatic logic codec_sel(input int j, input logic [15:0] l, input logic [15:0] r);
    if (j == 0)       return r[0];
    else if (j <= 16) return l[16-j];
    else if (j <= 31) return r[32-j];
    else              return 1'b0;
  endfunction
  always @(negedge sclk) begin
    if (!lrclk && lr_fall_prev) begin
      fidx      <= 0;
      codec_bit <= codec_r[0];
    end else begin
      fidx      <= fidx + 1;
      codec_bit <= codec_sel(fidx + 1, codec_l, codec_r);
    end
    lr_fall_prev <= lrclk;
  end

  // Codec DAC model: at rise 0 the previous 32 rises hold {left, right}
  logic [31:0] dec_shft = 32'h0;
  logic [31:0] last_dec = 32'h0;
  logic        lr_rise_prev = 1'b0;
  always @(posedge sclk) begin
    dec_shft <= {dec_shft[30:0], sdin};
    if (!lrclk && lr_rise_prev) last_dec <= {dec_shft[30:0], sdin};
    lr_rise_prev <= lrclk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int start;
    bit got;
    start = vcount;
    got   = 1'b0;
    for (int i = 0; i < 1100 && !got; i++) begin
      tick();
      if (vcount != start) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no valid pulse within 1100 cycles", tag);
    end
  endtask

  task automatic wait_cnt(input logic [9:0] target, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 1100 && !got; i++) begin
      tick();
      if (bcnt == target) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: frame position %h never reached", tag, target);
    end
  endtask

  // After release: RSTn at 1024, one discarded frame, first valid at cnt 0x010 of frame 2
  task automatic startup(input string tag);
    int start;
    bit got;
    start = vcount;
    got   = 1'b0;
    for (int i = 0; i < 2200 && !got; i++) begin
      tick();
      if (vcount != start) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_first_valid: no valid within 2200 cycles", tag);
    end else begin
      chk({tag, "_first_valid_cycle"}, v_c, 32'd2065);
      chk({tag, "_first_adc"}, {v_l, v_r}, 32'hA5C3_3C5A);
    end
  endtask

  vec_t vecs [5];
  logic [15:0] pl, pr;

  initial begin
    vecs[0] = {16'hA5C3, 16'h3C5A, 16'h8001, 16'h7FFE, 16'hA5C3, 16'h3C5A, 16'h8001, 16'h7FFE};
    vecs[1] = {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[2] = {16'h0001, 16'h8000, 16'hAAAA, 16'h5555, 16'h0001, 16'h8000, 16'hAAAA, 16'h5555};
    vecs[3] = {16'h1234, 16'hFEDC, 16'h0F0F, 16'hF0F0, 16'h1234, 16'hFEDC, 16'h0F0F, 16'hF0F0};
    vecs[4] = {16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF};

    core_if.lft_dac = 16'h8001;
    core_if.rht_dac = 16'h7FFE;
    codec_l = 16'hA5C3;
    codec_r = 16'h3C5A;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_adc", {core_if.lft_adc, core_if.rht_adc}, 32'h0);
    chk("rst_pins", {26'h0, core_if.valid, sdin, rstn, lrclk, sclk, mclk}, 32'h0);
    rst = 1'b0;
    startup("t1");

    // Vector table: codec words on SDout, core words on SDin
    for (int i = 0; i < 5; i++) begin
      codec_l = vecs[i].codec_l;
      codec_r = vecs[i].codec_r;
      core_if.lft_dac = vecs[i].dac_l;
      core_if.rht_dac = vecs[i].dac_r;
      wait_valid($sformatf("vec%0d_a", i));
      wait_valid($sformatf("vec%0d_b", i));
      chk($sformatf("vec%0d_adc", i), {v_l, v_r}, {vecs[i].exp_adc_l, vecs[i].exp_adc_r});
      chk($sformatf("vec%0d_sdin", i), last_dec, {vecs[i].exp_sd_l, vecs[i].exp_sd_r});
    end

    // DAC word changed after the load point waits for the next frame
    core_if.lft_dac = 16'h1234;
    core_if.rht_dac = 16'h5678;
    wait_cnt(10'h100, "t5_mid");
    core_if.lft_dac = 16'hFFFF;
    wait_valid("t5_a");
    chk("t5_hold", last_dec, 32'h1234_5678);
    wait_valid("t5_b");
    chk("t5_next", last_dec, 32'hFFFF_5678);

    // Loopback: each word comes back at the valid of the frame after its load
    loopback = 1'b1;
    wait_valid("loop_start");
    pl = 16'h0000;
    pr = 16'h0000;
    for (int k = 0; k <= 50; k++) begin
      if (k > 0) chk($sformatf("loop%0d", k), {v_l, v_r}, {pl, pr});
      pl = 16'(k);
      pr = 16'hFFFF - 16'(k);
      core_if.lft_dac = pl;
      core_if.rht_dac = pr;
      if (k < 50) wait_valid($sformatf("loop%0d_wait", k));
    end

    // Mid-frame reset at cnt 0x300
    loopback = 1'b0;
    codec_l = 16'hA5C3;
    codec_r = 16'h3C5A;
    wait_cnt(10'h300, "t6_pos");
    rst = 1'b1;
    tick();
    chk("t6_adc", {core_if.lft_adc, core_if.rht_adc}, 32'h0);
    chk("t6_pins", {26'h0, core_if.valid, sdin, rstn, lrclk, sclk, mclk}, 32'h0);
    rst = 1'b0;
    startup("t6");

    chk("clock_taps", 32'(wave_err), 32'h0);
    chk("valid_position", 32'(vpos_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
